uart_tx: RTL and testbench

Byte-serial UART transmitter with a small input FIFO. It sits directly downstream of the priRV32 top level: core logic pushes bytes over a valid/ready handshake, and the block serialises them onto the board TX pin as 8N1 frames. It uses the same `Clock`/`Baud` parameterisation as the top level, which passes its own values straight through.

---
 rtl/uart_tx_if.sv | 10 +
 rtl/uart_tx.sv | 135 +++++++++++++
 tb/tb_uart_tx.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte handshake between the core and the UART transmitter.
// The core is the master and the transmitter FIFO is the slave.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small power-of-two FIFO.
// Frames run back to back whenever the FIFO holds data at the end of a stop bit.
module uart_tx #(
  parameter int Clock = 50,
  parameter int Baud  = 115200,
  parameter int Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_tx_if.slave                 up,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(Depth):0]   fifo_level
);

  localparam int BIT_CYCLES = (Clock * 1000000) / Baud;
  localparam int CNT_W      = ($clog2(BIT_CYCLES) < 1) ? 1 : $clog2(BIT_CYCLES);
  localparam int PTR_W      = $clog2(Depth);
  localparam int LVL_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(Depth);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [7:0]       fifo_mem_q [Depth];

  logic push;
  logic pop;

  // No pop-bypass: a full FIFO refuses a byte even on a pop edge.
  assign up.tx_ready = !rst && (level_q != LVL_FULL);
  assign push        = up.tx_valid && up.tx_ready;

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || (level_q != '0);
  assign fifo_level = level_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (level_q != '0) begin
          pop       = 1'b1;
          shreg_d   = fifo_mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          state_d   = START;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (bit_cnt_q == CNT_LAST) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
          tx_d      = shreg_q[0];
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_cnt_q == CNT_LAST) begin
          bit_cnt_d = '0;
          shreg_d   = shreg_q >> 1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shreg_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_cnt_q == CNT_LAST) begin
          bit_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (level_q != '0) begin
            pop     = 1'b1;
            shreg_d = fifo_mem_q[rd_ptr_q];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
    end
    shreg_q <= shreg_d;
    if (push) fifo_mem_q[wr_ptr_q] <= up.tx_data;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (bit times 434, 4 and 2 clocks) checked every
// cycle against a queue-and-frame-timer model, plus literal frame and timing checks.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s  [3];
  logic       valid  [3];
  logic [7:0] data   [3];
  logic       tx_w   [3];
  logic       busy_w [3];
  logic       rdy_w  [3];
  logic [2:0] lvl_w  [3];

  int n_chk  = 0;
  int n_fail = 0;

  uart_tx_if if0 ();
  uart_tx_if if1 ();
  uart_tx_if if2 ();

  assign if0.tx_valid = valid[0];
  assign if0.tx_data  = data[0];
  assign rdy_w[0]     = if0.tx_ready;
  assign if1.tx_valid = valid[1];
  assign if1.tx_data  = data[1];
  assign rdy_w[1]     = if1.tx_ready;
  assign if2.tx_valid = valid[2];
  assign if2.tx_data  = data[2];
  assign rdy_w[2]     = if2.tx_ready;

  uart_tx #(.Clock(50), .Baud(115200), .Depth(4)) u0 (
    .clk(clk), .rst(rst_s[0]), .up(if0), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_level(lvl_w[0]));
  uart_tx #(.Clock(1), .Baud(250000), .Depth(4)) u1 (
    .clk(clk), .rst(rst_s[1]), .up(if1), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_level(lvl_w[1]));
  uart_tx #(.Clock(1), .Baud(500000), .Depth(4)) u2 (
    .clk(clk), .rst(rst_s[2]), .up(if2), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_level(lvl_w[2]));

  function automatic int bc(input int k);
    case (k)
      0:       return 434;
      1:       return 4;
      default: return 2;
    endcase
  endfunction

  // Reference model: a byte list plus the frame being sent and its elapsed cycle count.
  bit         known [3];
  bit         mact  [3];
  int         mt    [3];
  int         mcnt  [3];
  logic [7:0] mframe[3];
  logic [7:0] mlist [3][4];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_s[k]) begin
        known[k] = 1'b1;
        mact[k]  = 1'b0;
        mcnt[k]  = 0;
        mt[k]    = 0;
      end else begin
        int   pre;
        logic acc;
        pre = mcnt[k];
        acc = valid[k] && (mcnt[k] != 4);
        if (mact[k]) begin
          mt[k]++;
          if (mt[k] == 10 * bc(k)) mact[k] = 1'b0;
        end
        if (!mact[k] && pre != 0) begin
          mframe[k] = mlist[k][0];
          for (int j = 0; j < 3; j++) mlist[k][j] = mlist[k][j+1];
          mcnt[k]--;
          mact[k] = 1'b1;
          mt[k]   = 0;
        end
        if (acc) begin
          mlist[k][mcnt[k]] = data[k];
          mcnt[k]++;
        end
      end
    end
  end

  function automatic logic exp_tx(input int k);
    int idx;
    if (!mact[k]) return 1'b1;
    idx = mt[k] / bc(k);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return mframe[k][idx-1];
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      if (known[k]) begin
        chk("model_tx", k, 32'(tx_w[k]), 32'(exp_tx(k)));
        chk("model_busy", k, 32'(busy_w[k]), 32'(mact[k] || (mcnt[k] != 0)));
        chk("model_level", k, 32'(lvl_w[k]), 32'(mcnt[k]));
        chk("model_ready", k, 32'(rdy_w[k]), 32'(!rst_s[k] && (mcnt[k] != 4)));
      end
    end
  endtask

  task automatic drive(input int k, input logic v, input logic [7:0] d);
    @(posedge clk);
    #2;
    valid[k] = v;
    data[k]  = d;
  endtask

  // Counts busy negedges and samples tx mid-bit, bit 0 being the start bit at offset off.
  task automatic frame_check(input int k, input int off, input int nbits,
                             output logic [19:0] bits, output int bcnt);
    int idx;
    bits = '0;
    bcnt = 0;
    idx  = 0;
    for (int n = 0; n < 20 * bc(k) + 60; n++) begin
      @(negedge clk);
      if (busy_w[k] !== 1'b1) break;
      bcnt++;
      if (n >= off && idx < nbits && ((n - off) % bc(k)) == bc(k) / 2) begin
        bits[idx] = tx_w[k];
        idx++;
      end
    end
  endtask

  task automatic wait_idle(input int k);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (busy_w[k] === 1'b0) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
    $fatal(1);
  end

  initial begin
    logic [19:0] bits;
    int          bcnt;
    int          bad;
    int          acc;
    int          b;
    bit          seen5;

    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b1;
      valid[k] = 1'b0;
      data[k]  = 8'h00;
    end

    fork
      forever begin
        @(negedge clk);
        compare_all();
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_tx", k, 32'(tx_w[k]), 32'd1);
      chk("rst_busy", k, 32'(busy_w[k]), 32'd0);
      chk("rst_level", k, 32'(lvl_w[k]), 32'd0);
      chk("rst_ready", k, 32'(rdy_w[k]), 32'd0);
    end
    @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("ready_after_rst", k, 32'(rdy_w[k]), 32'd1);

    // Idle hold
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rdy_w[0] !== 1'b1) bad++;
    end
    chk("idle_hold_bad_cycles", 0, 32'(bad), 32'd0);

    // Single 0x55 at default rates: start + 1,0,1,0,1,0,1,0 + stop -> 10'h2AA
    drive(0, 1'b1, 8'h55);
    drive(0, 1'b0, 8'h00);
    frame_check(0, 1, 10, bits, bcnt);
    chk("single_bits", 0, 32'(bits[9:0]), 32'h2AA);
    chk("single_busy_cycles", 0, 32'(bcnt), 32'd4341);

    // Back-to-back 0xA5, 0x3C: frames 10'h34A then 10'h278, 80 contiguous clocks
    drive(1, 1'b1, 8'hA5);
    drive(1, 1'b1, 8'h3C);
    drive(1, 1'b0, 8'h00);
    frame_check(1, 0, 20, bits, bcnt);
    chk("b2b_frame1", 1, 32'(bits[9:0]), 32'h34A);
    chk("b2b_frame2", 1, 32'(bits[19:10]), 32'h278);
    chk("b2b_busy_cycles", 1, 32'(bcnt), 32'd80);

    // Backpressure with 0x01..0x08 held valid
    acc   = 0;
    b     = 1;
    seen5 = 1'b0;
    drive(1, 1'b1, 8'h01);
    for (int n = 0; n < 600; n++) begin
      logic r;
      @(negedge clk);
      r = rdy_w[1];
      if (acc == 5 && !seen5) begin
        seen5 = 1'b1;
        chk("full_level", 1, 32'(lvl_w[1]), 32'd4);
        chk("full_ready", 1, 32'(r), 32'd0);
      end
      @(posedge clk);
      if (r) begin
        acc++;
        b++;
      end
      #2;
      if (acc == 8) begin
        valid[1] = 1'b0;
        break;
      end
      data[1] = 8'(b);
    end
    valid[1] = 1'b0;
    chk("full_accepted", 1, 32'(acc), 32'd8);
    wait_idle(1);

    // Reset during data bit 3 of the first of three queued frames
    drive(1, 1'b1, 8'h11);
    drive(1, 1'b1, 8'h22);
    drive(1, 1'b1, 8'h33);
    drive(1, 1'b0, 8'h00);
    repeat (15) @(posedge clk);
    #2;
    rst_s[1] = 1'b1;
    @(negedge clk);
    chk("midrst_ready_low", 1, 32'(rdy_w[1]), 32'd0);
    @(posedge clk);
    #2;
    rst_s[1] = 1'b0;
    @(negedge clk);
    chk("midrst_tx", 1, 32'(tx_w[1]), 32'd1);
    chk("midrst_level", 1, 32'(lvl_w[1]), 32'd0);
    chk("midrst_busy", 1, 32'(busy_w[1]), 32'd0);
    bad = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (busy_w[1] !== 1'b0 || tx_w[1] !== 1'b1) bad++;
    end
    chk("midrst_no_frames", 1, 32'(bad), 32'd0);
    // 0xF0 -> 10'h3E0
    drive(1, 1'b1, 8'hF0);
    drive(1, 1'b0, 8'h00);
    frame_check(1, 1, 10, bits, bcnt);
    chk("post_rst_bits", 1, 32'(bits[9:0]), 32'h3E0);
    chk("post_rst_busy_cycles", 1, 32'(bcnt), 32'd41);

    // Two-clock bit time, 0x80 -> 10'h300 over 20 clocks
    drive(2, 1'b1, 8'h80);
    drive(2, 1'b0, 8'h00);
    frame_check(2, 1, 10, bits, bcnt);
    chk("div2_bits", 2, 32'(bits[9:0]), 32'h300);
    chk("div2_busy_cycles", 2, 32'(bcnt), 32'd21);

    // Randomized traffic with occasional resets
    for (int k = 1; k < 3; k++) begin
      for (int n = 0; n < 3000; n++) begin
        @(posedge clk);
        #2;
        valid[k] = ($urandom_range(0, 2) == 0);
        data[k]  = 8'($urandom);
        rst_s[k] = ($urandom_range(0, 399) == 0);
      end
      @(posedge clk);
      #2;
      valid[k] = 1'b0;
      rst_s[k] = 1'b0;
      wait_idle(k);
      chk("random_drained", k, 32'(busy_w[k]), 32'd0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
